// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I execute-stage ALU.
package alu_pkg;

  localparam int XLEN = 32;

  // Operation codes; encodings 12..15 are treated as NOP by the ALU.
  typedef enum logic [3:0] {
    OP_LUI  = 4'd0,
    OP_LW   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_OR   = 4'd4,
    OP_AND  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SUB  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLTU = 4'd11
  } alu_op_t;

  // Barrel shifter direction/fill selection.
  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } sh_mode_t;

  // Signed overflow of a two's-complement add/sub, judged from sign bits only.
  // For subtraction the caller passes the inverted sign of the subtrahend.
  function automatic logic signed_ovfl(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter covering SLL, SRL and SRA.
// Left shifts reuse the right-shift stages by bit-reversing input and output.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  sh_mode_t         mode_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] stage [0:SHW];
  logic             left;
  logic             fill;

  assign left = (mode_i == SH_SLL);
  // Only arithmetic right shift replicates the sign; the others fill with zero.
  assign fill = (mode_i == SH_SRA) & data_i[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev_in
      assign rev_in[gi] = data_i[WIDTH-1-gi];
    end
  endgenerate

  assign stage[0] = left ? rev_in : data_i;

  // Stage gi conditionally shifts right by 2**gi.
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      assign stage[gi+1] = amt_i[gi]
        ? {{(1 << gi){fill}}, stage[gi][WIDTH-1:(1 << gi)]}
        : stage[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev_out
      assign rev_out[gi] = stage[SHW][WIDTH-1-gi];
    end
  endgenerate

  assign data_o = left ? rev_out : stage[SHW];

endmodule

// File: rtl/alu.sv
// RV32I execute-stage integer ALU with a registered result and overflow flag.
// One operation is accepted every cycle; results appear one edge later.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Control,
  output logic [WIDTH-1:0] Out,
  output logic             ovfl
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_t          op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shift_res;
  sh_mode_t         sh_mode;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             ovfl_d;
  logic             ovfl_q;

  assign op          = alu_op_t'(Control);
  assign sum         = A + B;
  assign diff        = A - B;
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;

  // Pick the shifter mode from the opcode; non-shift ops leave it at SRL (unused).
  always_comb begin
    sh_mode = SH_SRL;
    case (op)
      OP_SLL:  sh_mode = SH_SLL;
      OP_SRA:  sh_mode = SH_SRA;
      default: sh_mode = SH_SRL;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .data_i (A),
    .amt_i  (B[SHW-1:0]),
    .mode_i (sh_mode),
    .data_o (shift_res)
  );

  // Result and overflow mux; unknown or NOP codes fall through to zero.
  always_comb begin
    out_d  = '0;
    ovfl_d = 1'b0;
    case (op)
      OP_LUI:  out_d = B;
      OP_LW:   out_d = sum;
      OP_ADD: begin
        out_d  = sum;
        ovfl_d = signed_ovfl(A[WIDTH-1], B[WIDTH-1], sum[WIDTH-1]);
      end
      OP_XOR:  out_d = A ^ B;
      OP_OR:   out_d = A | B;
      OP_AND:  out_d = A & B;
      OP_SLL,
      OP_SRL,
      OP_SRA:  out_d = shift_res;
      OP_SUB: begin
        out_d  = diff;
        ovfl_d = signed_ovfl(A[WIDTH-1], ~B[WIDTH-1], diff[WIDTH-1]);
      end
      OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: out_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default: begin
        out_d  = '0;
        ovfl_d = 1'b0;
      end
    endcase
  end

  // Output register; reset clears it immediately and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      ovfl_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      ovfl_q <= ovfl_d;
    end
  end

  assign Out  = out_q;
  assign ovfl = ovfl_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Control;
  logic [31:0] Out;
  logic        ovfl;

  int total = 0;
  int bad   = 0;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .Control (Control),
    .Out     (Out),
    .ovfl    (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp_o, input logic exp_v);
    total++;
    assert (Out === exp_o) else begin
      bad++;
      $error("FAIL %s Out: got %08h want %08h", tag, Out, exp_o);
    end
    total++;
    assert (ovfl === exp_v) else begin
      bad++;
      $error("FAIL %s ovfl: got %0b want %0b", tag, ovfl, exp_v);
    end
    $display("%s: ctl=%0d A=%08h B=%08h Out=%08h ovfl=%0b", tag, Control, A, B, Out, ovfl);
  endtask

  // Drive one op after the falling edge, check it just after the next rising edge.
  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_o, input logic exp_v);
    @(negedge clk);
    Control = ctl;
    A       = a;
    B       = b;
    @(posedge clk);
    #1;
    check(tag, exp_o, exp_v);
  endtask

  logic [31:0] sweep_exp [16];

  initial begin
    sweep_exp[0]  = 32'h00000002;
    sweep_exp[1]  = 32'hF00000A4;
    sweep_exp[2]  = 32'hF00000A4;
    sweep_exp[3]  = 32'hF00000A0;
    sweep_exp[4]  = 32'hF00000A2;
    sweep_exp[5]  = 32'h00000002;
    sweep_exp[6]  = 32'hC0000288;
    sweep_exp[7]  = 32'h3C000028;
    sweep_exp[8]  = 32'hFC000028;
    sweep_exp[9]  = 32'hF00000A0;
    sweep_exp[10] = 32'h00000001;
    sweep_exp[11] = 32'h00000000;
    for (int i = 12; i < 16; i++) sweep_exp[i] = 32'h00000000;

    rst_n   = 1'b0;
    A       = 32'h12345678;
    B       = 32'h00000001;
    Control = 4'd2;
    #3;
    check("reset_init", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("sweep%0d", i), 4'(i), 32'hF00000A2, 32'h00000002, sweep_exp[i], 1'b0);
    end

    run_op("add_ovf", 4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
    run_op("sub_ovf", 4'd9, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    run_op("lw_noovf", 4'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
    run_op("add_neg_ovf", 4'd2, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    run_op("sub_noovf", 4'd9, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0);

    run_op("sll31", 4'd6, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0);
    run_op("sra31", 4'd8, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0);
    run_op("srl31", 4'd7, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);
    run_op("sll32", 4'd6, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0);
    run_op("sll0", 4'd6, 32'h13579BDF, 32'h00000000, 32'h13579BDF, 1'b0);
    run_op("sra4", 4'd8, 32'h8000F000, 32'h00000004, 32'hF8000F00, 1'b0);
    run_op("sll5", 4'd6, 32'h0000000F, 32'hFFFFFFE5, 32'h000001E0, 1'b0);

    run_op("slt_neg", 4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    run_op("sltu_big", 4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    run_op("slt_eq", 4'd10, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
    run_op("sltu_eq", 4'd11, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0);
    run_op("sltu_lt", 4'd11, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("slt_pos", 4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0);

    // Reset asserted between edges must clear the registers without a clock.
    run_op("pre_reset", 4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'h0, 1'b0);
    Control = 4'bxxxx;
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 1'b0);

    @(negedge clk);
    Control = 4'd2;
    A       = 32'h00000001;
    B       = 32'h00000002;
    #1;
    rst_n = 1'b1;
    #1;
    check("release_wait", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("release_first", 32'h00000003, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
